hdmi_i2c_init_seq: RTL

- Sequences HDMI-transmitter register configuration through the shared i2c_master, and arbitrates that master between the local init table and host (user_io) I2C requests.
- Sits in the core top level between user_io's i2c_* port and i2c_master; drives i2c_master exclusively.
- On reset release or HPD rising edge: waits a power-up delay, then writes every {subaddr,data} table entry to DEV_ADDR.

---
 rtl/hdmi_i2c_init_seq_if.sv | 25 ++
 rtl/hdmi_i2c_init_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_i2c_init_seq_if.sv
// I2C master request/response bundle between the init sequencer
// (master side) and i2c_master (slave side).
// Signals: i2c_start/read/addr/subaddr/dout out, i2c_din/end/ack back.
interface hdmi_i2c_init_seq_if;
   logic       i2c_start;
   logic       i2c_read;
   logic [6:0] i2c_addr;
   logic [7:0] i2c_subaddr;
   logic [7:0] i2c_dout;
   logic [7:0] i2c_din;
   logic       i2c_end;
   logic       i2c_ack;

   modport master (
      output i2c_start, i2c_read, i2c_addr,
      output i2c_subaddr, i2c_dout,
      input  i2c_din, i2c_end, i2c_ack
   );

   modport slave (
      input  i2c_start, i2c_read, i2c_addr,
      input  i2c_subaddr, i2c_dout,
      output i2c_din, i2c_end, i2c_ack
   );
endinterface

// File: rtl/hdmi_i2c_init_seq.sv
// HDMI transmitter init sequencer: on reset release or HPD rise it
// waits a power-up delay, then writes every {subaddr,data} table
// entry to DEV_ADDR through i2c_master; idle slots serve host
// requests. Ports: clk_sys/reset, hpd, tbl_addr/tbl_data (table ROM),
// h_* (host request/response), i2c (master modport), busy/done/err.
module hdmi_i2c_init_seq #(
   parameter logic [6:0] DEV_ADDR  = 7'h39,
   parameter int         TBL_AW    = 6,
   parameter int         PWR_DELAY = 24000,
   parameter int         MAX_RETRY = 3,
   parameter int         TIMEOUT   = 65535
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              hpd,
   output logic [TBL_AW-1:0] tbl_addr,
   input  logic [15:0]       tbl_data,
   input  logic              h_start,
   input  logic              h_read,
   input  logic [6:0]        h_addr,
   input  logic [7:0]        h_subaddr,
   input  logic [7:0]        h_wdata,
   output logic [7:0]        h_rdata,
   output logic              h_end,
   output logic              h_ack,
   hdmi_i2c_init_seq_if.master i2c,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_DELAY  = 4'd1;
   localparam logic [3:0] S_FETCH  = 4'd2;
   localparam logic [3:0] S_FWAIT  = 4'd3;
   localparam logic [3:0] S_ISSUE  = 4'd4;
   localparam logic [3:0] S_WAIT   = 4'd5;
   localparam logic [3:0] S_NEXT   = 4'd6;
   localparam logic [3:0] S_DONE   = 4'd7;
   localparam logic [3:0] S_HISSUE = 4'd8;
   localparam logic [3:0] S_HWAIT  = 4'd9;

   localparam logic [31:0] DLY_END = 32'(PWR_DELAY - 1);
   localparam logic [31:0] TMO_END = 32'(TIMEOUT - 1);
   localparam logic [7:0]  RMAX    = 8'(MAX_RETRY);

   logic [3:0]  state;
   logic [31:0] cnt;
   logic [7:0]  retry;

   // hpd_q starts at 0 so a high hpd after reset reads as a rise
   logic hpd_m, hpd_s, hpd_q;
   logic rise, start_seq;
   logic trig_pend;

   logic       hpend;
   logic       hp_read;
   logic [6:0] hp_addr;
   logic [7:0] hp_sub;
   logic [7:0] hp_wdata;

   assign rise      = hpd_s & ~hpd_q;
   assign start_seq = (trig_pend | rise) & hpd_s;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state           <= S_IDLE;
         cnt             <= '0;
         retry           <= '0;
         hpd_m           <= 1'b0;
         hpd_s           <= 1'b0;
         hpd_q           <= 1'b0;
         trig_pend       <= 1'b0;
         hpend           <= 1'b0;
         hp_read         <= 1'b0;
         hp_addr         <= '0;
         hp_sub          <= '0;
         hp_wdata        <= '0;
         tbl_addr        <= '0;
         h_rdata         <= '0;
         h_end           <= 1'b0;
         h_ack           <= 1'b0;
         i2c.i2c_start   <= 1'b0;
         i2c.i2c_read    <= 1'b0;
         i2c.i2c_addr    <= '0;
         i2c.i2c_subaddr <= '0;
         i2c.i2c_dout    <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err             <= 1'b0;
      end else begin
         hpd_m         <= hpd;
         hpd_s         <= hpd_m;
         hpd_q         <= hpd_s;
         i2c.i2c_start <= 1'b0;
         h_end         <= 1'b0;

         if (h_start && !hpend) begin
            hpend    <= 1'b1;
            hp_read  <= h_read;
            hp_addr  <= h_addr;
            hp_sub   <= h_subaddr;
            hp_wdata <= h_wdata;
         end

         // a rise during a host transaction is kept for the next IDLE
         if (rise && !busy && state != S_IDLE)
            trig_pend <= 1'b1;

         case (state)
            S_IDLE: begin
               trig_pend <= 1'b0;
               if (start_seq) begin
                  state    <= S_DELAY;
                  cnt      <= '0;
                  retry    <= '0;
                  tbl_addr <= '0;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  err      <= 1'b0;
               end else if (hpend) begin
                  state <= S_HISSUE;
               end
            end
            S_DELAY: begin
               if (!hpd_s) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (cnt == DLY_END) begin
                  state <= S_FETCH;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            S_FETCH: begin
               if (!hpd_s) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  state <= S_FWAIT;
               end
            end
            S_FWAIT: begin
               if (!hpd_s) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (tbl_data == 16'hFFFF) begin
                  state <= S_DONE;
               end else begin
                  i2c.i2c_read    <= 1'b0;
                  i2c.i2c_addr    <= DEV_ADDR;
                  i2c.i2c_subaddr <= tbl_data[15:8];
                  i2c.i2c_dout    <= tbl_data[7:0];
                  state           <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               i2c.i2c_start <= 1'b1;
               cnt           <= '0;
               state         <= S_WAIT;
            end
            S_WAIT: begin
               if (i2c.i2c_end) begin
                  if (!i2c.i2c_ack && retry == RMAX)
                     err <= 1'b1;
                  if (!hpd_s) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else if (i2c.i2c_ack || retry == RMAX) begin
                     state <= S_NEXT;
                  end else begin
                     retry <= retry + 8'd1;
                     state <= S_ISSUE;
                  end
               end else if (cnt == TMO_END) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            S_NEXT: begin
               tbl_addr <= tbl_addr + 1'b1;
               retry    <= '0;
               if (!hpd_s) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (&tbl_addr) begin
                  state <= S_DONE;
               end else begin
                  state <= S_FETCH;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= S_IDLE;
            end
            S_HISSUE: begin
               i2c.i2c_read    <= hp_read;
               i2c.i2c_addr    <= hp_addr;
               i2c.i2c_subaddr <= hp_sub;
               i2c.i2c_dout    <= hp_wdata;
               i2c.i2c_start   <= 1'b1;
               cnt             <= '0;
               state           <= S_HWAIT;
            end
            S_HWAIT: begin
               if (i2c.i2c_end) begin
                  h_end   <= 1'b1;
                  h_ack   <= i2c.i2c_ack;
                  h_rdata <= i2c.i2c_din;
                  hpend   <= 1'b0;
                  state   <= S_IDLE;
               end else if (cnt == TMO_END) begin
                  // a stuck host request completes as NACK
                  h_end <= 1'b1;
                  h_ack <= 1'b0;
                  hpend <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
